// File: rtl/nmr_bstrm_pkg.sv
// Shared types and defaults for the NMR bitstream pulse-train datapath.
//   bstrm_st_t  : train phase state
//   bstrm_ent_t : phase-entry request used while resolving zero-length phases
package nmr_bstrm_pkg;

  typedef enum logic [2:0] {IDLE, IDLY, PLS, GAP, EDLY} bstrm_st_t;

  typedef enum logic [2:0] {ENT_NONE, ENT_IDLY, ENT_GAP, ENT_PLS, ENT_EDLY} bstrm_ent_t;

  localparam int unsigned DEF_IDLY_WIDTH = 32;
  localparam int unsigned DEF_PLS_WIDTH  = 32;
  localparam int unsigned DEF_GAP_WIDTH  = 32;
  localparam int unsigned DEF_EDLY_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nmr_bstrm_dcnt.sv
// Loadable down-counter with zero flag, one per train (shared by all phases).
//   clk_i, rst_ni : clock, async active-low reset
//   ld_i/ld_val_i : load (priority over enable)
//   en_i          : decrement; saturates at zero
//   zero_o        : count is zero (last cycle of the current phase)
module nmr_bstrm_dcnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  cnt_q <= '0;
    else if (ld_i)                cnt_q <= ld_val_i;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nmr_bstrm_pls_train.sv
// Programmable NMR pulse train: initial delay, npls pulses separated by gaps,
// end delay. Zero-length phases are skipped within the same edge.
//   CLK, RST       : clock, async active-low reset
//   START          : rising-edge train request (acted on in IDLE only)
//   ABORT          : level, returns to IDLE without DONE
//   idly/pls/gap/edly/npls/inv : train configuration, latched at start
//   OUT            : registered bitstream, (state==PLS) ^ inv
//   BUSY, DONE     : train active, one-cycle completion strobe
//   PLS_CNT        : pulses started in current / last train
module nmr_bstrm_pls_train
  import nmr_bstrm_pkg::*;
#(
  parameter int unsigned IDLY_WIDTH = DEF_IDLY_WIDTH,
  parameter int unsigned PLS_WIDTH  = DEF_PLS_WIDTH,
  parameter int unsigned GAP_WIDTH  = DEF_GAP_WIDTH,
  parameter int unsigned EDLY_WIDTH = DEF_EDLY_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [IDLY_WIDTH-1:0] idly,
  input  logic [PLS_WIDTH-1:0]  pls,
  input  logic [GAP_WIDTH-1:0]  gap,
  input  logic [EDLY_WIDTH-1:0] edly,
  input  logic [CNT_WIDTH-1:0]  npls,
  input  logic                  inv,
  output logic                  OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [CNT_WIDTH-1:0]  PLS_CNT
);

  localparam int unsigned MAXW = max2(max2(IDLY_WIDTH, PLS_WIDTH), max2(GAP_WIDTH, EDLY_WIDTH));

  bstrm_st_t             st_q, st_d;
  bstrm_ent_t            ent;
  logic                  start_q, start_edge, go;
  logic [PLS_WIDTH-1:0]  pls_q, u_pls;
  logic [GAP_WIDTH-1:0]  gap_q, u_gap;
  logic [EDLY_WIDTH-1:0] edly_q, u_edly;
  logic [CNT_WIDTH-1:0]  npls_q, u_npls;
  logic [CNT_WIDTH-1:0]  pcnt_q, pcnt_d;
  logic                  inv_q, inv_d;
  logic                  out_q, busy_q, done_q, done_d;
  logic                  ld, cnt_en, zero;
  logic [MAXW-1:0]       ldv;

  nmr_bstrm_dcnt #(.W(MAXW)) u_dcnt (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .ld_i     (ld),
    .ld_val_i (ldv),
    .en_i     (cnt_en),
    .zero_o   (zero)
  );

  always_comb begin
    start_edge = START & ~start_q;
    go         = (st_q == IDLE) & start_edge & ~ABORT;
    // On the start edge the live inputs are used; later phases see the latched copy.
    u_pls  = go ? pls  : pls_q;
    u_gap  = go ? gap  : gap_q;
    u_edly = go ? edly : edly_q;
    u_npls = go ? npls : npls_q;
    inv_d  = go ? inv  : inv_q;

    st_d   = st_q;
    pcnt_d = pcnt_q;
    ld     = 1'b0;
    ldv    = '0;
    done_d = 1'b0;
    ent    = ENT_NONE;
    cnt_en = (st_q != IDLE) & ~zero;

    if (st_q == IDLE) begin
      if (go) begin
        ent    = ENT_IDLY;
        pcnt_d = '0;
      end
    end else if (ABORT) begin
      st_d = IDLE;
    end else if (zero) begin
      case (st_q)
        IDLY:    ent = ENT_PLS;
        PLS:     ent = (pcnt_q == u_npls) ? ENT_EDLY : ENT_GAP;
        GAP:     ent = ENT_PLS;
        EDLY:    begin st_d = IDLE; done_d = 1'b1; end
        default: st_d = IDLE;
      endcase
    end

    // Resolve chains of zero-length phases in order; each stage either
    // settles on a timed phase or forwards to the next entry point.
    // idly is only consulted on the start edge, so it needs no latch.
    if (ent == ENT_IDLY) begin
      if (idly != '0) begin
        st_d = IDLY; ld = 1'b1; ldv = MAXW'(idly - IDLY_WIDTH'(1)); ent = ENT_NONE;
      end else ent = ENT_PLS;
    end
    if (ent == ENT_GAP) begin
      if (u_gap != '0) begin
        st_d = GAP; ld = 1'b1; ldv = MAXW'(u_gap - GAP_WIDTH'(1)); ent = ENT_NONE;
      end else ent = ENT_PLS;
    end
    if (ent == ENT_PLS) begin
      if (pcnt_d == u_npls) begin
        ent = ENT_EDLY;
      end else if (u_pls != '0) begin
        st_d = PLS; pcnt_d = pcnt_d + 1'b1;
        ld = 1'b1; ldv = MAXW'(u_pls - PLS_WIDTH'(1)); ent = ENT_NONE;
      end else if (u_gap == '0) begin
        // Zero pulse and zero gap: every remaining pulse is entered at once.
        pcnt_d = u_npls; ent = ENT_EDLY;
      end else begin
        pcnt_d = pcnt_d + 1'b1;
        if (pcnt_d == u_npls) ent = ENT_EDLY;
        else begin
          st_d = GAP; ld = 1'b1; ldv = MAXW'(u_gap - GAP_WIDTH'(1)); ent = ENT_NONE;
        end
      end
    end
    if (ent == ENT_EDLY) begin
      if (u_edly != '0) begin
        st_d = EDLY; ld = 1'b1; ldv = MAXW'(u_edly - EDLY_WIDTH'(1));
      end else if (go) begin
        // Zero-length train still holds BUSY for one cycle before DONE.
        st_d = EDLY; ld = 1'b1; ldv = '0;
      end else begin
        st_d = IDLE; done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st_q    <= IDLE;
      start_q <= 1'b0;
      pls_q   <= '0;
      gap_q   <= '0;
      edly_q  <= '0;
      npls_q  <= '0;
      inv_q   <= 1'b0;
      pcnt_q  <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      start_q <= START;
      if (go) begin
        pls_q  <= pls;
        gap_q  <= gap;
        edly_q <= edly;
        npls_q <= npls;
      end
      inv_q   <= inv_d;
      pcnt_q  <= pcnt_d;
      out_q   <= (st_d == PLS) ^ inv_d;
      busy_q  <= (st_d != IDLE);
      done_q  <= done_d;
    end
  end

  assign OUT     = out_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PLS_CNT = pcnt_q;

endmodule

// File: tb/tb_nmr_bstrm_pls_train.sv
module tb_nmr_bstrm_pls_train;

  localparam int CW = 4;

  logic          CLK, RST, START, ABORT, inv;
  logic [31:0]   idly, pls, gap, edly;
  logic [CW-1:0] npls;
  logic          OUT, BUSY, DONE;
  logic [CW-1:0] PLS_CNT;

  int checks = 0;
  int failures = 0;

  logic [63:0] out_tr, busy_tr, done_tr;

  nmr_bstrm_pls_train #(.CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .idly(idly), .pls(pls), .gap(gap), .edly(edly), .npls(npls), .inv(inv),
    .OUT(OUT), .BUSY(BUSY), .DONE(DONE), .PLS_CNT(PLS_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m(input int lo, input int hi);
    logic [63:0] r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic cfg(input int i_idly, input int i_pls, input int i_gap, input int i_edly,
                     input int i_npls, input logic i_inv);
    idly = i_idly; pls = i_pls; gap = i_gap; edly = i_edly; npls = CW'(i_npls); inv = i_inv;
  endtask

  // Index i in the traces is the state just after edge k+i (k = start edge).
  task automatic launch(input int n, input int hold, input int abort_at, input int restart_at);
    out_tr = '0; busy_tr = '0; done_tr = '0;
    for (int i = 0; i < n; i++) begin
      START = (i < hold) || (i == restart_at);
      ABORT = (i == abort_at);
      @(posedge CLK); #1;
      out_tr[i] = OUT; busy_tr[i] = BUSY; done_tr[i] = DONE;
    end
    START = 1'b0; ABORT = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1'b0; START = 1'b0; ABORT = 1'b0;
    cfg(0, 0, 0, 0, 0, 1'b0);
    #12;
    chk("rst_out", OUT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_cnt", PLS_CNT, 0);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1;

    // reset mid-train
    cfg(5, 7, 3, 5, 3, 1'b0);
    START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    chk("mid_busy", BUSY, 1);
    chk("mid_out", OUT, 1);
    #2 RST = 1'b0;
    #1;
    chk("arst_out", OUT, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_cnt", PLS_CNT, 0);
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("arst_idle_busy", BUSY, 0);
    chk("arst_idle_done", DONE, 0);

    // nominal three-pulse train, T=37
    cfg(5, 7, 3, 5, 3, 1'b0);
    launch(40, 1, -1, -1);
    chk("a_out", out_tr, m(5, 11) | m(15, 21) | m(25, 31));
    chk("a_busy", busy_tr, m(0, 36));
    chk("a_done", done_tr, m(37, 37));
    chk("a_cnt", PLS_CNT, 3);

    // zero idly/gap/edly, pulses merge
    cfg(0, 4, 0, 0, 2, 1'b0);
    launch(12, 1, -1, -1);
    chk("z1_out", out_tr, m(0, 7));
    chk("z1_busy", busy_tr, m(0, 7));
    chk("z1_done", done_tr, m(8, 8));
    chk("z1_cnt", PLS_CNT, 2);

    // npls=0
    cfg(2, 4, 0, 3, 0, 1'b0);
    launch(8, 1, -1, -1);
    chk("z2_out", out_tr, 0);
    chk("z2_busy", busy_tr, m(0, 4));
    chk("z2_done", done_tr, m(5, 5));
    chk("z2_cnt", PLS_CNT, 0);

    // all-zero train
    cfg(0, 0, 0, 0, 0, 1'b0);
    launch(4, 1, -1, -1);
    chk("z3_busy", busy_tr, m(0, 0));
    chk("z3_done", done_tr, m(1, 1));

    // inverted polarity, START held 20 cycles
    cfg(1, 2, 0, 1, 1, 1'b1);
    launch(24, 20, -1, -1);
    chk("inv_out", out_tr, m(0, 23) & ~m(1, 2));
    chk("inv_busy", busy_tr, m(0, 3));
    chk("inv_done", done_tr, m(4, 4));
    chk("inv_idle_out", OUT, 1);

    // abort in second pulse, restart during busy ignored
    cfg(5, 7, 3, 5, 3, 1'b0);
    launch(30, 1, 17, 8);
    chk("ab_out", out_tr, m(5, 11) | m(15, 16));
    chk("ab_busy", busy_tr, m(0, 16));
    chk("ab_done", done_tr, 0);
    chk("ab_cnt", PLS_CNT, 2);

    // abort coincident with start edge
    cfg(1, 1, 1, 1, 1, 1'b0);
    launch(8, 1, 0, -1);
    chk("abst_busy", busy_tr, 0);
    chk("abst_done", done_tr, 0);
    chk("abst_cnt", PLS_CNT, 2);

    // full-scale pulse count
    cfg(0, 1, 1, 0, 15, 1'b0);
    launch(32, 1, -1, -1);
    chk("fs_out", out_tr, 64'h15555555);
    chk("fs_busy", busy_tr, m(0, 28));
    chk("fs_done", done_tr, m(29, 29));
    chk("fs_cnt", PLS_CNT, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
